dmem_responder: RTL

- Responder side of the processor data-memory interface: services the core's loads and stores against a word-organised data RAM.
- Performs byte/halfword lane steering and sign/zero extension.
- Redirects device-tagged stores into an 8-bit transmit FIFO drained over a valid/ready handshake to an external serial sink.
- Sits in the wrapper between the core's memory-stage outputs and the dmem/IO resources. Also exposes a read-only MMIO status word.

---
 rtl/dmem_responder_if.sv | 40 ++++
 rtl/dmem_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - core data-memory and IO transmit signal bundle
// Purpose: groups the core memory-stage request/response signals and the
//          transmit-FIFO sink handshake shared by dmem_responder and its user.
// Signals:
//   cpu_addr[31:0]       word address from the core
//   cpu_byte_off[1:0]    byte offset within the word
//   cpu_write_data[31:0] unshifted store data
//   cpu_write_en         one-cycle store strobe
//   cpu_read_type[2:0]   funct3 of the load/store
//   cpu_device_id        1 = store targets the IO device
//   cpu_read_data[31:0]  extended load result (responder -> core)
//   io_tx_data[7:0]      transmit FIFO head byte
//   io_tx_valid          transmit FIFO non-empty
//   io_tx_ready          sink accepts the head byte this cycle
//   io_overflow          sticky device-store drop flag
interface dmem_responder_if;
  logic [31:0] cpu_addr;
  logic [1:0]  cpu_byte_off;
  logic [31:0] cpu_write_data;
  logic        cpu_write_en;
  logic [2:0]  cpu_read_type;
  logic        cpu_device_id;
  logic [31:0] cpu_read_data;
  logic [7:0]  io_tx_data;
  logic        io_tx_valid;
  logic        io_tx_ready;
  logic        io_overflow;

  modport master (
    output cpu_addr, cpu_byte_off, cpu_write_data, cpu_write_en,
           cpu_read_type, cpu_device_id, io_tx_ready,
    input  cpu_read_data, io_tx_data, io_tx_valid, io_overflow
  );

  modport slave (
    input  cpu_addr, cpu_byte_off, cpu_write_data, cpu_write_en,
           cpu_read_type, cpu_device_id, io_tx_ready,
    output cpu_read_data, io_tx_data, io_tx_valid, io_overflow
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with lane steering and IO transmit FIFO
// Purpose: services core loads/stores against a word RAM, steers byte/halfword
//          lanes with sign/zero extension, diverts device stores into an
//          8-bit transmit FIFO and exposes a read-only status word.
// Ports:
//   clock  rising-edge master clock
//   reset  asynchronous active-high reset (FIFO/overflow state only, not RAM)
//   bus    dmem_responder_if.slave: core request/response and IO sink handshake
module dmem_responder #(
  parameter int ADDR_W       = 12,
  parameter int FIFO_DEPTH   = 8,
  parameter int STATUS_WADDR = 509
) (
  input  logic             clock,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      mem_q [2**ADDR_W];
  logic [7:0]       fifo_q [FIFO_DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       ovf_cnt_q, ovf_cnt_d;
  logic             overflow_q, overflow_d;

  logic [ADDR_W-1:0] waddr;
  logic [31:0]       ram_word;
  logic [31:0]       rd_word;
  logic [31:0]       status_word;
  logic [7:0]        count_ext;
  logic              full;
  logic              is_status;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [31:0]       read_data;

  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              tx_valid;

  logic              unused_addr_hi;
  assign unused_addr_hi = &{1'b0, bus.cpu_addr[31:ADDR_W]};

  assign waddr     = bus.cpu_addr[ADDR_W-1:0];
  assign ram_word  = mem_q[waddr];
  assign is_status = (waddr == ADDR_W'(STATUS_WADDR));

  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign count_ext   = 8'(count_q);
  assign status_word = {16'd0, ovf_cnt_q, 3'd0, full, count_ext[3:0]};

  // Status shadows the RAM word at its address; RAM underneath still takes stores.
  assign rd_word = is_status ? status_word : ram_word;

  always_comb begin
    sel_byte = rd_word[7:0];
    case (bus.cpu_byte_off)
      2'd0:    sel_byte = rd_word[7:0];
      2'd1:    sel_byte = rd_word[15:8];
      2'd2:    sel_byte = rd_word[23:16];
      default: sel_byte = rd_word[31:24];
    endcase
    // Halfword lane uses only the upper offset bit (aligned down).
    sel_half = bus.cpu_byte_off[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    read_data = rd_word;
    case (bus.cpu_read_type)
      3'd0:    read_data = {{24{sel_byte[7]}}, sel_byte};
      3'd1:    read_data = {{16{sel_half[15]}}, sel_half};
      3'd4:    read_data = {24'd0, sel_byte};
      3'd5:    read_data = {16'd0, sel_half};
      default: read_data = rd_word;
    endcase
  end

  assign bus.cpu_read_data = read_data;

  // Store lane merge: read-modify-write of the addressed RAM word.
  always_comb begin
    ram_we    = 1'b0;
    ram_wdata = ram_word;
    if (bus.cpu_write_en && !bus.cpu_device_id) begin
      case (bus.cpu_read_type)
        3'd0: begin
          ram_we = 1'b1;
          case (bus.cpu_byte_off)
            2'd0:    ram_wdata[7:0]   = bus.cpu_write_data[7:0];
            2'd1:    ram_wdata[15:8]  = bus.cpu_write_data[7:0];
            2'd2:    ram_wdata[23:16] = bus.cpu_write_data[7:0];
            default: ram_wdata[31:24] = bus.cpu_write_data[7:0];
          endcase
        end
        3'd1: begin
          ram_we = 1'b1;
          if (bus.cpu_byte_off[1]) ram_wdata[31:16] = bus.cpu_write_data[15:0];
          else                     ram_wdata[15:0]  = bus.cpu_write_data[15:0];
        end
        3'd2: begin
          ram_we    = 1'b1;
          ram_wdata = bus.cpu_write_data;
        end
        default: ram_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we) mem_q[waddr] <= ram_wdata;
  end

  assign tx_valid = (count_q != '0);
  assign pop      = tx_valid && bus.io_tx_ready;
  assign push_req = bus.cpu_write_en && bus.cpu_device_id;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign push_ok  = push_req && (!full || pop);

  always_ff @(posedge clock) begin
    if (push_ok) fifo_q[wr_ptr_q] <= bus.cpu_write_data[7:0];
  end

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ovf_cnt_d  = ovf_cnt_q;
    overflow_d = overflow_q;

    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);

    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (push_req && !push_ok) begin
      overflow_d = 1'b1;
      if (ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ovf_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ovf_cnt_q  <= ovf_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage is not reset; gating with valid gives a clean zero when empty.
  assign bus.io_tx_valid = tx_valid;
  assign bus.io_tx_data  = tx_valid ? fifo_q[rd_ptr_q] : 8'd0;
  assign bus.io_overflow = overflow_q;

endmodule
